// File: rtl/fifo_rd_streamer_if.sv
// Bundle of the FIFO read port and the outgoing framed stream.
// master: the streamer side; slave: the FIFO/sink environment side.
interface fifo_rd_streamer_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int PKT_LEN_BIT = 2
);
  logic                   en;
  logic                   fifo_empty;
  logic                   fifo_r_en;
  logic [DATA_WIDTH-1:0]  fifo_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_WIDTH-1:0]  out_data;
  logic                   out_last;
  logic [PKT_LEN_BIT-1:0] beat_idx;

  modport master (
    input  en, fifo_empty, fifo_data, out_ready,
    output fifo_r_en, out_valid, out_data, out_last, beat_idx
  );

  modport slave (
    output en, fifo_empty, fifo_data, out_ready,
    input  fifo_r_en, out_valid, out_data, out_last, beat_idx
  );
endinterface

// File: rtl/fifo_rd_streamer.sv
// Drains a synchronous FIFO read port into a valid/ready stream with
// packet framing. A 2-entry skid buffer hides the FIFO's 1-cycle read
// latency so the stream sustains one word per cycle.
module fifo_rd_streamer #(
  parameter int DATA_WIDTH  = 8,
  parameter int PKT_LEN     = 4,
  parameter int PKT_LEN_BIT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  fifo_rd_streamer_if.master bus
);

  localparam logic [PKT_LEN_BIT-1:0] LP_LAST_BEAT = PKT_LEN_BIT'(PKT_LEN - 1);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } buf_state_t;

  buf_state_t             r_state;
  buf_state_t             w_state_nxt;
  logic [DATA_WIDTH-1:0]  r_head;
  logic [DATA_WIDTH-1:0]  r_skid;
  logic [DATA_WIDTH-1:0]  w_head_nxt;
  logic [DATA_WIDTH-1:0]  w_skid_nxt;
  logic                   r_pending;
  logic [PKT_LEN_BIT-1:0] r_beat;

  logic [1:0]             w_buf_cnt;
  logic [2:0]             w_occ;
  logic                   w_valid;
  logic                   w_fire;
  logic                   w_rd_en;

  assign w_valid = (r_state != S_EMPTY);
  assign w_fire  = w_valid & bus.out_ready;
  assign w_occ   = {1'b0, w_buf_cnt} + {2'b00, r_pending};

  // Gating with rst_n keeps r_en low for the whole reset window, not just after
  // the registers clear; out_ready feeds this path combinationally on purpose.
  assign w_rd_en = rst_n & bus.en & ~bus.fifo_empty
                 & ((w_occ - {2'b00, w_fire}) < 3'd2);

  assign bus.fifo_r_en = w_rd_en;
  assign bus.out_valid = w_valid;
  assign bus.out_data  = r_head;
  assign bus.beat_idx  = r_beat;
  assign bus.out_last  = w_valid & (r_beat == LP_LAST_BEAT);

  // Decode buffer occupancy from the buffer state.
  always_comb begin
    w_buf_cnt = 2'd0;
    case (r_state)
      S_ONE:   w_buf_cnt = 2'd1;
      S_TWO:   w_buf_cnt = 2'd2;
      default: w_buf_cnt = 2'd0;
    endcase
  end

  // Buffer state and data movement: capture appends at the tail, fire pops the head.
  always_comb begin
    w_state_nxt = r_state;
    w_head_nxt  = r_head;
    w_skid_nxt  = r_skid;
    case (r_state)
      S_EMPTY: begin
        if (r_pending) begin
          w_head_nxt  = bus.fifo_data;
          w_state_nxt = S_ONE;
        end
      end
      S_ONE: begin
        if (w_fire && r_pending) begin
          w_head_nxt = bus.fifo_data;
        end else if (w_fire) begin
          w_state_nxt = S_EMPTY;
        end else if (r_pending) begin
          w_skid_nxt  = bus.fifo_data;
          w_state_nxt = S_TWO;
        end
      end
      S_TWO: begin
        // A capture without a fire cannot occur here: the issue rule reserves
        // a slot for every outstanding read.
        if (w_fire) begin
          w_head_nxt = r_skid;
          if (r_pending) begin
            w_skid_nxt = bus.fifo_data;
          end else begin
            w_state_nxt = S_ONE;
          end
        end
      end
      default: begin
        w_state_nxt = S_EMPTY;
      end
    endcase
  end

  // Buffer state and storage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
      r_head  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_head  <= w_head_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

  // Mark that FIFO data is due next edge; reset discards a read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= 1'b0;
    end else begin
      r_pending <= w_rd_en;
    end
  end

  // Beat counter advances on each accepted word and wraps at the packet end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat <= '0;
    end else if (w_fire) begin
      if (r_beat == LP_LAST_BEAT) begin
        r_beat <= '0;
      end else begin
        r_beat <= r_beat + PKT_LEN_BIT'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Scoreboard bench for fifo_rd_streamer: a behavioural FIFO feeds the DUT,
// every pushed word is queued as expected output, and a monitor compares
// each accepted beat against the queue and a packet-position model.
module tb_fifo_rd_streamer;

  localparam int DW      = 8;
  localparam int PL      = 4;
  localparam int PLB     = 2;
  localparam int MEM_SZ  = 1024;

  logic clk;
  logic rst_n;

  fifo_rd_streamer_if #(.DATA_WIDTH(DW), .PKT_LEN_BIT(PLB)) bus ();

  fifo_rd_streamer #(
    .DATA_WIDTH (DW),
    .PKT_LEN    (PL),
    .PKT_LEN_BIT(PLB)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] mem [MEM_SZ];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  logic [DW-1:0] exp_q [$];

  int            beat_model  = 0;
  int            outstanding = 0;
  logic          prev_stall  = 1'b0;
  logic [DW-1:0] prev_data   = '0;

  assign bus.fifo_empty = (wr_ptr == rd_ptr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural synchronous FIFO: data appears the cycle after a pop, junk otherwise.
  always @(posedge clk) begin
    if (bus.fifo_r_en && !bus.fifo_empty) begin
      bus.fifo_data <= mem[rd_ptr % MEM_SZ];
      rd_ptr        <= rd_ptr + 1;
    end else begin
      bus.fifo_data <= DW'($urandom);
    end
  end

  // Monitor: compare every accepted beat and the stream invariants.
  always @(negedge clk) begin
    if (!rst_n) begin
      beat_model  = 0;
      outstanding = 0;
      prev_stall  = 1'b0;
    end else begin
      if (bus.fifo_empty) check("ren_while_empty", 32'(bus.fifo_r_en), 32'd0);
      if (prev_stall) begin
        check("stall_valid", 32'(bus.out_valid), 32'd1);
        check("stall_data", 32'(bus.out_data), 32'(prev_data));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=0x%0h expected=none at %0t", bus.out_data, $time);
        end else begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          check("beat_data", 32'(bus.out_data), 32'(e));
          check("beat_idx", 32'(bus.beat_idx), 32'(beat_model));
          check("beat_last", 32'(bus.out_last), 32'(beat_model == PL - 1));
        end
        beat_model = (beat_model + 1) % PL;
      end
      outstanding = outstanding + int'(bus.fifo_r_en && !bus.fifo_empty)
                                - int'(bus.out_valid && bus.out_ready);
      check("occupancy_bound", 32'(outstanding <= 2), 32'd1);
      prev_stall = bus.out_valid & ~bus.out_ready;
      prev_data  = bus.out_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    mem[wr_ptr % MEM_SZ] = d;
    wr_ptr = wr_ptr + 1;
    exp_q.push_back(d);
  endtask

  // Words still in the FIFO survive a reset; anything already popped is lost.
  task automatic rebuild_expected();
    exp_q.delete();
    for (int p = rd_ptr; p < wr_ptr; p++) exp_q.push_back(mem[p % MEM_SZ]);
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    #1;
    rebuild_expected();
    @(negedge clk);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic drain(input string name);
    int n;
    bus.en = 1'b1;
    bus.out_ready = 1'b1;
    n = 0;
    while (n < 300 && !(exp_q.size() == 0 && !bus.out_valid && bus.fifo_empty)) begin
      @(negedge clk);
      #2;
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (n < 20 && !bus.out_valid) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(bus.out_valid), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.en = 1'b0;
    bus.out_ready = 1'b0;
    bus.fifo_data = '0;

    // Reset state, with a word waiting and en high so r_en gating is visible.
    push(8'hA5);
    bus.en = 1'b1;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_out_last", 32'(bus.out_last), 32'd0);
    check("rst_beat_idx", 32'(bus.beat_idx), 32'd0);
    check("rst_fifo_r_en", 32'(bus.fifo_r_en), 32'd0);

    // Single word: one r_en pulse, out_valid two cycles later.
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("single_ren_pulse", 32'(bus.fifo_r_en), 32'd1);
    @(negedge clk);
    check("single_ren_off", 32'(bus.fifo_r_en), 32'd0);
    check("single_valid_early", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("single_valid", 32'(bus.out_valid), 32'd1);
    check("single_data", 32'(bus.out_data), 32'hA5);
    check("single_idx", 32'(bus.beat_idx), 32'd0);
    check("single_last", 32'(bus.out_last), 32'd0);
    check("single_ren_after", 32'(bus.fifo_r_en), 32'd0);
    repeat (2) @(negedge clk);
    check("single_drained", 32'(bus.out_valid), 32'd0);

    // Streaming 0x01..0x08 from a fresh packet: no gaps.
    bus.en = 1'b0;
    do_reset();
    for (int i = 1; i <= 8; i++) push(DW'(i));
    bus.en = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    wait_valid("stream_start");
    for (int i = 0; i < 8; i++) begin
      check("stream_nogap", 32'(bus.out_valid), 32'd1);
      @(negedge clk);
    end
    drain("stream_drain");

    // Backpressure: stall 5 cycles mid-stream.
    for (int i = 0; i < 12; i++) push(DW'($urandom));
    repeat (4) tick();
    bus.out_ready = 1'b0;
    for (int s = 1; s <= 5; s++) begin
      @(negedge clk);
      #2;
      if (s >= 3) begin
        check("stall_no_ren", 32'(bus.fifo_r_en), 32'd0);
        check("stall_full", 32'(outstanding), 32'd2);
      end
    end
    tick();
    bus.out_ready = 1'b1;
    drain("stall_drain");

    // en dropped right after an accepted pop: that word still arrives.
    bus.en = 1'b0;
    for (int i = 0; i < 6; i++) push(DW'($urandom));
    tick();
    bus.en = 1'b1;
    @(negedge clk);
    check("en_ren_seen", 32'(bus.fifo_r_en), 32'd1);
    tick();
    bus.en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("en_low_no_ren", 32'(bus.fifo_r_en), 32'd0);
    end
    drain("en_drain");

    // Empty boundary: 3 words leave the counter at 3; the next word is last.
    bus.en = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) push(DW'(8'h30 + i));
    drain("empty_drain");
    @(negedge clk);
    check("empty_valid", 32'(bus.out_valid), 32'd0);
    check("empty_idx", 32'(bus.beat_idx), 32'd3);
    check("empty_ren", 32'(bus.fifo_r_en), 32'd0);
    tick();
    push(8'h77);
    @(negedge clk);
    wait_valid("empty_next_valid");
    check("empty_next_last", 32'(bus.out_last), 32'd1);
    drain("empty_next_drain");

    // Asynchronous reset mid-cycle with the buffer full.
    bus.out_ready = 1'b0;
    bus.en = 1'b0;
    for (int i = 0; i < 6; i++) push(DW'($urandom));
    bus.en = 1'b1;
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.out_valid), 32'd0);
    check("arst_last", 32'(bus.out_last), 32'd0);
    check("arst_idx", 32'(bus.beat_idx), 32'd0);
    check("arst_ren", 32'(bus.fifo_r_en), 32'd0);
    rebuild_expected();
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    drain("arst_drain");

    // Randomized en / out_ready / push traffic.
    for (int c = 0; c < 400; c++) begin
      tick();
      bus.en        = ($urandom % 4) != 0;
      bus.out_ready = ($urandom % 3) != 0;
      if (($urandom % 2) != 0) push(DW'($urandom));
    end
    drain("random_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
